// File: rtl/uart_transceiver_pkg.sv
// Shared bit-timing helpers and FSM state types for the 8N1 UART.
// Timing is a whole number of clocks per bit, fixed at elaboration.
package uart_transceiver_pkg;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

    function automatic int symbol_edge_time(
        input int clock_freq,
        input int baud_rate
    );
        return clock_freq / baud_rate;
    endfunction

    function automatic int sample_time(
        input int clock_freq,
        input int baud_rate
    );
        return symbol_edge_time(clock_freq, baud_rate) / 2;
    endfunction

    // Never narrower than one bit, even for a one-clock symbol.
    function automatic int counter_width(
        input int clock_freq,
        input int baud_rate
    );
        int set;
        set = symbol_edge_time(clock_freq, baud_rate);
        return (set > 1) ? $clog2(set) : 1;
    endfunction

    typedef enum logic {
        TX_IDLE,
        TX_SEND
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver with a two-flop input synchronizer and mid-bit sampling.
// A good frame overwrites data_out; a framing error drops the byte.
module uart_rx
    import uart_transceiver_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready
);

    localparam int SET    = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int SAMPLE = sample_time(CLOCK_FREQ, BAUD_RATE);
    localparam int CW     = counter_width(CLOCK_FREQ, BAUD_RATE);

    localparam logic [CW-1:0] LAST = CW'(SET - 1);
    localparam logic [CW-1:0] HALF = CW'((SAMPLE > 0) ? SAMPLE - 1 : 0);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    logic          meta;
    logic          rx;
    rx_state_t     state;
    rx_state_t     state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_next;
    logic [7:0]    shifter;
    logic [7:0]    shifter_next;
    logic [7:0]    data_next;
    logic          valid_next;
    logic          sample_data;
    logic          frame_good;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta           <= 1'b1;
            rx             <= 1'b1;
            state          <= RX_IDLE;
            cnt            <= '0;
            bit_idx        <= '0;
            shifter        <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else begin
            meta           <= serial_in;
            rx             <= meta;
            state          <= state_next;
            cnt            <= cnt_next;
            bit_idx        <= bit_idx_next;
            shifter        <= shifter_next;
            data_out       <= data_next;
            data_out_valid <= valid_next;
        end
    end

    // START re-checks the line half a bit in; DATA/STOP then land mid-bit.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bit_idx_next = bit_idx;
        unique case (state)
            RX_IDLE: begin
                if (!rx) begin
                    state_next = RX_START;
                    cnt_next   = '0;
                end
            end
            RX_START: begin
                if (cnt == HALF) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    state_next   = rx ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt == LAST) begin
                    cnt_next     = '0;
                    bit_idx_next = bit_idx + 3'd1;
                    if (bit_idx == LAST_BIT) begin
                        state_next = RX_STOP;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt == LAST) begin
                    cnt_next   = '0;
                    state_next = RX_IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // A completing frame wins over a same-cycle consume.
    always_comb begin
        sample_data  = (state == RX_DATA) && (cnt == LAST);
        frame_good   = (state == RX_STOP) && (cnt == LAST) && rx;
        shifter_next = sample_data ? {rx, shifter[7:1]} : shifter;
        data_next    = frame_good ? shifter : data_out;
        valid_next   = data_out_valid;
        if (frame_good) begin
            valid_next = 1'b1;
        end else if (data_out_valid && data_out_ready) begin
            valid_next = 1'b0;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter: accepts one byte per handshake, shifts it out LSB first.
// serial_out is registered so the start bit follows the handshake edge.
module uart_tx
    import uart_transceiver_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       serial_out
);

    localparam int SET = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int CW  = counter_width(CLOCK_FREQ, BAUD_RATE);

    localparam logic [CW-1:0] LAST     = CW'(SET - 1);
    localparam logic [3:0]    STOP_IDX = 4'(FRAME_BITS - 1);

    tx_state_t     state;
    tx_state_t     state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [3:0]    bit_idx;
    logic [3:0]    bit_idx_next;
    logic [8:0]    shifter;
    logic [8:0]    shifter_next;
    logic          serial_next;
    logic          bit_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= TX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shifter    <= '1;
            serial_out <= 1'b1;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            bit_idx    <= bit_idx_next;
            shifter    <= shifter_next;
            serial_out <= serial_next;
        end
    end

    // Shifter holds the remaining data bits with the stop bit behind them.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bit_idx_next = bit_idx;
        shifter_next = shifter;
        serial_next  = serial_out;
        bit_done     = (cnt == LAST);
        unique case (state)
            TX_IDLE: begin
                if (data_in_valid) begin
                    state_next   = TX_SEND;
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    shifter_next = {1'b1, data_in};
                    serial_next  = 1'b0;
                end
            end
            TX_SEND: begin
                if (!bit_done) begin
                    cnt_next = cnt + 1'b1;
                end else begin
                    cnt_next = '0;
                    if (bit_idx == STOP_IDX) begin
                        state_next  = TX_IDLE;
                        serial_next = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx + 4'd1;
                        serial_next  = shifter[0];
                        shifter_next = {1'b1, shifter[8:1]};
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        data_in_ready = (state == TX_IDLE);
    end

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: independent transmit and receive byte streams.
// Pure wiring between the ports and the two direction engines.
module uart_transceiver
    import uart_transceiver_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       serial_out,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready
);

    uart_tx #(
        .CLOCK_FREQ(CLOCK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) u_tx (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready),
        .serial_out   (serial_out)
    );

    uart_rx #(
        .CLOCK_FREQ(CLOCK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) u_rx (
        .clk           (clk),
        .reset         (reset),
        .serial_in     (serial_in),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready)
    );

endmodule

// File: tb/tb_uart_transceiver.sv
// Bench for uart_transceiver: frame-level model of both directions,
// directed scenarios plus randomized loopback and bit-banged frames.
module tb_uart_transceiver;

    localparam int CLOCK_FREQ = 50_000_000;
    localparam int BAUD_RATE  = 10_000_000;
    localparam int SET        = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE     = SET / 2;
    localparam int FRAME      = 10 * SET;
    localparam int NOM        = 2 + 9 * SET + SAMPLE;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_in_valid = 1'b0;
    logic       data_in_ready;
    logic       serial_out;
    logic       serial_in;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready = 1'b1;
    logic       loopback = 1'b1;
    logic       line = 1'b1;

    assign serial_in = loopback ? serial_out : line;

    uart_transceiver #(
        .CLOCK_FREQ(CLOCK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .serial_out    (serial_out),
        .serial_in     (serial_in),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic check(input string name, input bit ok,
                         input int act, input int exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Frame-level model: remaining frame cycles and the 10-bit frame.
    int         tx_left = 0;
    logic [9:0] tx_frame = 10'h3FF;
    int         hs_cyc[$];
    logic       consumed = 1'b0;
    logic [7:0] exp_b[$];
    int         exp_due[$];

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            tx_left = 0;
            consumed = 1'b0;
            exp_b.delete();
            exp_due.delete();
        end else begin
            consumed = data_out_valid && data_out_ready;
            if (tx_left > 0) begin
                tx_left--;
            end else if (data_in_valid) begin
                tx_left = FRAME;
                tx_frame = {1'b1, data_in, 1'b0};
                hs_cyc.push_back(cyc);
                if (loopback) begin
                    exp_b.push_back(data_in);
                    exp_due.push_back(cyc + 1 + NOM);
                end
            end
        end
    end

    logic       exp_serial;
    logic       prev_valid = 1'b0;
    logic [7:0] prev_data = 8'h00;
    int         rx_count = 0;
    logic [7:0] rx_last = 8'h00;

    always @(negedge clk) begin
        if (reset) begin
            check("rst_serial_out", serial_out === 1'b1, int'(serial_out), 1);
            check("rst_ready", data_in_ready === 1'b1, int'(data_in_ready), 1);
            check("rst_valid", data_out_valid === 1'b0, int'(data_out_valid), 0);
            check("rst_data", data_out === 8'h00, int'(data_out), 0);
            prev_valid = 1'b0;
            prev_data = 8'h00;
        end else begin
            exp_serial = (tx_left == 0) ? 1'b1 : tx_frame[(FRAME - tx_left) / SET];
            check("tx_serial", serial_out === exp_serial,
                  int'(serial_out), int'(exp_serial));
            check("tx_ready", data_in_ready === (tx_left == 0),
                  int'(data_in_ready), int'(tx_left == 0));
            if (data_out_valid && (!prev_valid || consumed)) begin
                if (exp_b.size() == 0) begin
                    check("rx_spurious", 1'b0, int'(data_out), 0);
                end else begin
                    check("rx_byte", data_out === exp_b[0],
                          int'(data_out), int'(exp_b[0]));
                    check("rx_latency",
                          cyc >= exp_due[0] - 1 && cyc <= exp_due[0] + 1,
                          cyc, exp_due[0]);
                    void'(exp_b.pop_front());
                    void'(exp_due.pop_front());
                end
                rx_count++;
                rx_last = data_out;
            end else if (prev_valid && !consumed) begin
                check("rx_hold",
                      data_out_valid === 1'b1 && data_out === prev_data,
                      int'({data_out_valid, data_out}),
                      int'({1'b1, prev_data}));
            end
            if (exp_due.size() > 0 && cyc > exp_due[0] + 1) begin
                check("rx_timeout", 1'b0, cyc, exp_due[0]);
                void'(exp_b.pop_front());
                void'(exp_due.pop_front());
            end
            prev_valid = data_out_valid;
            prev_data = data_out;
        end
    end

    task automatic send(input logic [7:0] b, input bit keep);
        int n;
        n = 0;
        @(negedge clk);
        data_in = b;
        data_in_valid = 1'b1;
        while (data_in_ready !== 1'b1 && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check("tx_accept", data_in_ready === 1'b1, n, 0);
        @(negedge clk);
        if (!keep) data_in_valid = 1'b0;
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        @(negedge clk);
        if (stop) begin
            exp_b.push_back(b);
            exp_due.push_back(cyc + 1 + NOM);
        end
        for (int i = 0; i < 10; i++) begin
            line = f[i];
            repeat (SET) @(negedge clk);
        end
        line = 1'b1;
    endtask

    logic [9:0] a5_wave = 10'b1101001010;
    logic [7:0] rb;
    int bad;
    int low_cnt;
    int n;
    int cnt0;
    int held;

    initial begin
        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_serial_out", serial_out === 1'b1, int'(serial_out), 1);
        check("reset_ready", data_in_ready === 1'b1, int'(data_in_ready), 1);
        check("reset_valid", data_out_valid === 1'b0, int'(data_out_valid), 0);
        check("reset_data", data_out === 8'h00, int'(data_out), 0);
        @(posedge clk);
        #2 reset = 1'b0;

        // TX 0xA5 waveform against a literal
        send(8'hA5, 1'b0);
        bad = 0;
        low_cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (serial_out !== a5_wave[i / SET]) bad++;
            if (data_in_ready === 1'b0) low_cnt++;
            @(negedge clk);
        end
        check("a5_waveform", bad == 0, bad, 0);
        check("a5_ready_low", low_cnt == 50, low_cnt, 50);
        check("a5_ready_back", data_in_ready === 1'b1, int'(data_in_ready), 1);
        repeat (2 * SET) @(negedge clk);

        // Loopback 0x3C with consumer stalled
        data_out_ready = 1'b0;
        send(8'h3C, 1'b0);
        n = 0;
        while (data_out_valid !== 1'b1 && n < 3 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check("lb_valid_seen", data_out_valid === 1'b1, n, 0);
        check("lb_data_3c", data_out === 8'h3C, int'(data_out), 8'h3C);
        held = 0;
        repeat (10) begin
            @(negedge clk);
            if (data_out_valid === 1'b1) held++;
        end
        check("lb_valid_held", held == 10, held, 10);
        data_out_ready = 1'b1;
        @(negedge clk);
        check("lb_valid_clear", data_out_valid === 1'b0, int'(data_out_valid), 0);

        // Back-to-back with valid held high
        cnt0 = rx_count;
        send(8'h00, 1'b1);
        send(8'hFF, 1'b0);
        repeat (2 * FRAME) @(negedge clk);
        check("b2b_spacing", hs_cyc[$] - hs_cyc[$-1] == 51,
              hs_cyc[$] - hs_cyc[$-1], 51);
        check("b2b_count", rx_count == cnt0 + 2, rx_count - cnt0, 2);
        check("b2b_last", rx_last === 8'hFF, int'(rx_last), 8'hFF);

        // Glitch and framing error
        loopback = 1'b0;
        cnt0 = rx_count;
        @(negedge clk);
        line = 1'b0;
        @(negedge clk);
        line = 1'b1;
        repeat (FRAME + 20) @(negedge clk);
        check("glitch_no_valid", rx_count == cnt0 && data_out_valid === 1'b0,
              rx_count - cnt0, 0);
        drive_frame(8'h81, 1'b0);
        repeat (FRAME) @(negedge clk);
        check("framing_no_valid", rx_count == cnt0 && data_out_valid === 1'b0,
              rx_count - cnt0, 0);

        // Randomized bit-banged frames
        for (int i = 0; i < 10; i++) begin
            rb = 8'($urandom());
            drive_frame(rb, 1'b1);
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        repeat (FRAME) @(negedge clk);

        // Randomized loopback frames
        loopback = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rb = 8'($urandom());
            send(rb, 1'b0);
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        repeat (2 * FRAME) @(negedge clk);

        // Reset in the middle of bit 4
        send(8'hC3, 1'b0);
        repeat (4 * SET + 2) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_serial", serial_out === 1'b1, int'(serial_out), 1);
        check("mid_rst_valid", data_out_valid === 1'b0, int'(data_out_valid), 0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        cnt0 = rx_count;
        repeat (2 * FRAME) @(negedge clk);
        check("mid_rst_no_byte", rx_count == cnt0, rx_count - cnt0, 0);
        send(8'h5A, 1'b0);
        repeat (2 * FRAME) @(negedge clk);
        check("post_rst_count", rx_count == cnt0 + 1, rx_count - cnt0, 1);
        check("post_rst_5a", rx_last === 8'h5A, int'(rx_last), 8'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
